rs232_txd: RTL

//  RS232 (UART) transmitter, companion to the 16x-oversampled receiver on the same Clock16x domain.

---
 rtl/rs232_pkg.sv | 26 ++
 rtl/rs232_tx_bitclk.sv | 27 ++
 rtl/rs232_txd.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// ---------------------------------------------------------------------------
// rs232_pkg : shared constants, TX state encoding and parity helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rs232_pkg;

  localparam int TICKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged
  function automatic logic tx_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs232_tx_bitclk.sv
// ---------------------------------------------------------------------------
// rs232_tx_bitclk : 4-bit tick counter, bit_end strobes on the last tick of a bit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rs232_tx_bitclk
  import rs232_pkg::*;
(
  input  logic Clock16x,
  input  logic Reset,
  input  logic clear,
  output logic bit_end
);

  logic [3:0] tick;

  always_ff @(posedge Clock16x) begin
    if (Reset || clear) tick <= '0;
    else                tick <= tick + 4'd1;
  end

  assign bit_end = (tick == 4'(TICKS_PER_BIT - 1));

endmodule

`default_nettype wire

// File: rtl/rs232_txd.sv
// ---------------------------------------------------------------------------
// rs232_txd : 16x-clocked UART transmitter with one-word holding register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rs232_txd
  import rs232_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 Clock16x,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] DataIn,
  input  logic                 DataValid,
  output logic                 DataReady,
  output logic                 Txd,
  output logic                 Busy
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY_ODD != 0);

  tx_state_t            state;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shifter;
  logic                 par_bit;
  logic [2:0]           bit_cnt;
  logic                 bit_end;
  logic                 accept;
  logic                 last_stop;
  logic                 load;

  // Counter idles at zero, so every bit boundary is a natural 15->0 wrap
  rs232_tx_bitclk u_bitclk (
    .Clock16x (Clock16x),
    .Reset    (Reset),
    .clear    (state == IDLE),
    .bit_end  (bit_end)
  );

  assign accept    = DataValid & DataReady;
  assign last_stop = (state == STOP) && bit_end && (bit_cnt == LAST_STOP);
  assign load      = hold_full && ((state == IDLE) || last_stop);
  assign Busy      = (state != IDLE) | hold_full;

  always_ff @(posedge Clock16x) begin
    if (Reset) begin
      state     <= IDLE;
      Txd       <= 1'b1;
      hold      <= '0;
      hold_full <= 1'b0;
      DataReady <= 1'b1;
      shifter   <= '0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      // A load needs a full hold and an accept needs an empty one
      assert (!(accept && load));

      case (state)
        IDLE: ;
        START: if (bit_end) begin
          state   <= DATA;
          Txd     <= shifter[0];
          shifter <= shifter >> 1;
          bit_cnt <= '0;
        end
        DATA: if (bit_end) begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt <= '0;
            if (PARITY_EN != 0) begin
              state <= PARITY;
              Txd   <= par_bit;
            end else begin
              state <= STOP;
              Txd   <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            Txd     <= shifter[0];
            shifter <= shifter >> 1;
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          Txd   <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          Txd   <= 1'b1;
        end
      endcase

      // Load overrides the IDLE fallback above, giving zero-gap frames
      if (load) begin
        shifter   <= hold;
        par_bit   <= tx_parity(8'(hold), ODD);
        hold_full <= 1'b0;
        DataReady <= 1'b1;
        state     <= START;
        Txd       <= 1'b0;
      end

      if (accept) begin
        hold      <= DataIn;
        hold_full <= 1'b1;
        DataReady <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
